// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and widths for the pipe_skid_reg pipeline stage.
package pipe_skid_reg_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } st_e;

  // Entry count held in each state.
  function automatic logic [OCC_W-1:0] occ_of(input st_e s);
    logic [OCC_W-1:0] occ;
    occ = OCC_W'(0);
    case (s)
      ST_ONE:  occ = OCC_W'(1);
      ST_TWO:  occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Upstream/downstream valid-ready handshake of one pipeline stage.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 15
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_skid_reg_dffe_w.sv
// WIDTH-bit register with load enable and asynchronous active-low clear to RST_VAL.
module dffe_w #(
  parameter int unsigned      WIDTH   = 15,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush and BUBBLE value.
// PIPE_SKID_REG_SKID_EN adds the skid entry and a registered in_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 15,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus,
  output logic [OCC_W-1:0] occupancy
);

  st_e              state;
  st_e              state_nx;
  logic             accept_c;
  logic             deliver_c;
  logic             main_en_c;
  logic [WIDTH-1:0] main_d_c;
  logic [WIDTH-1:0] main_q;
`ifdef PIPE_SKID_REG_SKID_EN
  logic             skid_en_c;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
`endif

  assign accept_c  = bus.in_valid & bus.in_ready;
  assign deliver_c = bus.out_valid & bus.out_ready;

  // Next state and load muxes; flush overrides every handshake.
  always_comb begin
    state_nx  = state;
    main_en_c = 1'b0;
    main_d_c  = BUBBLE;
`ifdef PIPE_SKID_REG_SKID_EN
    skid_en_c = 1'b0;
`endif
    if (flush) begin
      state_nx  = ST_EMPTY;
      main_en_c = 1'b1;
      main_d_c  = BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept_c) begin
            main_en_c = 1'b1;
            main_d_c  = bus.in_data;
            state_nx  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_c && deliver_c) begin
            main_en_c = 1'b1;
            main_d_c  = bus.in_data;
`ifdef PIPE_SKID_REG_SKID_EN
          end else if (accept_c) begin
            skid_en_c = 1'b1;
            state_nx  = ST_TWO;
`endif
          end else if (deliver_c) begin
            main_en_c = 1'b1;
            main_d_c  = BUBBLE;
            state_nx  = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_REG_SKID_EN
        ST_TWO: begin
          if (deliver_c) begin
            main_en_c = 1'b1;
            main_d_c  = skid_q;
            state_nx  = ST_ONE;
          end
        end
`endif
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  dffe_w #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_main (
    .clk  (clk),
    .clrn (clrn),
    .en   (main_en_c),
    .d    (main_d_c),
    .q    (main_q)
  );

`ifdef PIPE_SKID_REG_SKID_EN
  dffe_w #(
    .WIDTH   (WIDTH),
    .RST_VAL (WIDTH'(0))
  ) u_skid (
    .clk  (clk),
    .clrn (clrn),
    .en   (skid_en_c),
    .d    (bus.in_data),
    .q    (skid_q)
  );

  // Ready is a pure flop so back-pressure never reaches upstream in the same cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_nx != ST_TWO);
    end
  end

  assign bus.in_ready = ready_q;
`else
  assign bus.in_ready = clrn & (~bus.out_valid | bus.out_ready);
`endif

  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_data  = main_q;
  assign occupancy     = occ_of(state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model compared every cycle plus directed literal checks.
module tb_pipe_skid_reg;

  localparam int unsigned W = 15;
`ifdef PIPE_SKID_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn;
  logic       flush0;
  logic       flush1;
  logic [1:0] occ0;
  logic [1:0] occ1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(W)) bus0 ();
  pipe_skid_reg_if #(.WIDTH(W)) bus1 ();

  pipe_skid_reg #(.WIDTH(W)) dut0 (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush0),
    .bus       (bus0),
    .occupancy (occ0)
  );

  pipe_skid_reg #(.WIDTH(W), .BUBBLE(15'h1234)) dut1 (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush1),
    .bus       (bus1),
    .occupancy (occ1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of held beats; capacity 2 with skid, 1 without.
  logic [W-1:0] q[$];
  logic [W-1:0] seen[$];
  bit           rdy_reg;

  function automatic logic exp_ready();
    if (SKID) return rdy_reg;
    return (clrn === 1'b1) && ((q.size() == 0) || (bus0.out_ready === 1'b1));
  endfunction

  always @(posedge clk or negedge clrn) begin : model_upd
    bit acc;
    bit del;
    if (!clrn) begin
      q.delete();
      rdy_reg = 1'b0;
    end else begin
      acc = (bus0.in_valid === 1'b1) && exp_ready();
      del = (q.size() > 0) && (bus0.out_ready === 1'b1);
      if (flush0) begin
        q.delete();
      end else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(bus0.in_data);
      end
      rdy_reg = (q.size() < 2);
    end
  end

  always @(negedge clk) begin : compare
    chk("out_valid", 32'(bus0.out_valid), 32'(q.size() > 0));
    chk("out_data", 32'(bus0.out_data), 32'((q.size() > 0) ? q[0] : W'(0)));
    chk("occupancy", 32'(occ0), 32'(q.size()));
    chk("in_ready", 32'(bus0.in_ready), 32'(exp_ready()));
    if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) seen.push_back(bus0.out_data);
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bus0.in_valid  = v;
    bus0.in_data   = d;
    bus0.out_ready = r;
    flush0         = f;
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] exp_order [10];
  int           found;

  initial begin
    clrn = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus0.out_valid), 0);
    chk("rst_data", 32'(bus0.out_data), 0);
    chk("rst_occ", 32'(occ0), 0);
    chk("rst_ready", 32'(bus0.in_ready), 0);
    chk("b1_rst_data", 32'(bus1.out_data), 32'h1234);

    @(posedge clk); #2;
    clrn = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ready_after_rst", 32'(bus0.in_ready), 1);

    // Second stage with BUBBLE=0x1234.
    chk("b1_idle_data", 32'(bus1.out_data), 32'h1234);
    chk("b1_idle_valid", 32'(bus1.out_valid), 0);
    bus1.in_valid = 1'b1; bus1.in_data = 15'h0055;
    cyc(1'b0, '0, 1'b1, 1'b0);
    bus1.in_valid = 1'b0;
    chk("b1_acc_data", 32'(bus1.out_data), 32'h0055);
    chk("b1_acc_valid", 32'(bus1.out_valid), 1);
    flush1 = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    flush1 = 1'b0;
    chk("b1_flush_data", 32'(bus1.out_data), 32'h1234);
    chk("b1_flush_valid", 32'(bus1.out_valid), 0);
    chk("b1_flush_occ", 32'(occ1), 0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b1, 1'b0);
      chk("stream_data", 32'(bus0.out_data), 32'(i));
      chk("stream_ready", 32'(bus0.in_ready), 1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_occ", 32'(occ0), 0);

    // Back-pressure.
    cyc(1'b1, 15'h0A0A, 1'b0, 1'b0);
    chk("bp_first_data", 32'(bus0.out_data), 32'h0A0A);
    cyc(1'b1, 15'h0B0B, 1'b0, 1'b0);
    chk("bp_occ", 32'(occ0), SKID ? 2 : 1);
    chk("bp_ready", 32'(bus0.in_ready), 0);
    chk("bp_head", 32'(bus0.out_data), 32'h0A0A);
    cyc(1'b1, 15'h0B0B, 1'b1, 1'b0);
    chk("bp_rel_data", 32'(bus0.out_data), 32'h0B0B);
    chk("bp_rel_ready", 32'(bus0.in_ready), 1);
    chk("bp_rel_occ", 32'(occ0), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a beat being offered.
    cyc(1'b1, 15'h0C0C, 1'b0, 1'b0);
    cyc(1'b1, 15'h0D0D, 1'b0, 1'b0);
    chk("pre_flush_occ", 32'(occ0), SKID ? 2 : 1);
    cyc(1'b1, 15'h7FFF, 1'b0, 1'b1);
    chk("flush_valid", 32'(bus0.out_valid), 0);
    chk("flush_data", 32'(bus0.out_data), 0);
    chk("flush_occ", 32'(occ0), 0);
    chk("flush_ready", 32'(bus0.in_ready), 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush coinciding with accept and deliver.
    cyc(1'b1, 15'h0101, 1'b1, 1'b0);
    cyc(1'b1, 15'h0202, 1'b1, 1'b1);
    chk("flush_ad_occ", 32'(occ0), 0);
    cyc(1'b0, '0, 1'b1, 1'b0);

`ifndef PIPE_SKID_REG_SKID_EN
    // Combinational ready follows out_ready within the cycle.
    cyc(1'b1, 15'h0021, 1'b0, 1'b0);
    bus0.in_data = 15'h0022;
    #1;
    chk("comb_ready_low", 32'(bus0.in_ready), 0);
    bus0.out_ready = 1'b1;
    #1;
    chk("comb_ready_high", 32'(bus0.in_ready), 1);
    @(posedge clk); #2;
    chk("comb_pass_data", 32'(bus0.out_data), 32'h0022);
    chk("comb_pass_occ", 32'(occ0), 1);
    chk("comb_pass_deliv", 32'(seen[seen.size()-1]), 32'h0021);
    cyc(1'b0, '0, 1'b1, 1'b0);
`endif

    // Asynchronous reset with entries held; inputs offered during reset are ignored.
    cyc(1'b1, 15'h0E0E, 1'b0, 1'b0);
    cyc(1'b1, 15'h0F0F, 1'b0, 1'b0);
    #1;
    clrn = 1'b0;
    bus0.in_data = 15'h1111;
    #1;
    chk("rst2_valid", 32'(bus0.out_valid), 0);
    chk("rst2_data", 32'(bus0.out_data), 0);
    chk("rst2_occ", 32'(occ0), 0);
    chk("rst2_ready", 32'(bus0.in_ready), 0);
    @(posedge clk); #2;
    clrn = 1'b1;
    bus0.in_valid = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("rst2_rel_ready", 32'(bus0.in_ready), 1);
    chk("rst2_rel_occ", 32'(occ0), 0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Delivered stream order and absence of squashed data.
    exp_order = '{15'h0001, 15'h0002, 15'h0003, 15'h0004, 15'h0005,
                  15'h0006, 15'h0007, 15'h0008, 15'h0A0A, 15'h0B0B};
    chk("seen_count_min", 32'(seen.size() >= 10), 1);
    for (int i = 0; i < 10; i++) begin
      if (i < seen.size()) chk("seen_order", 32'(seen[i]), 32'(exp_order[i]));
    end
    found = 0;
    foreach (seen[i]) if (seen[i] == 15'h7FFF || seen[i] == 15'h0202) found++;
    chk("no_squashed_beat", 32'(found), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register, successor to the fixed 15-bit clear-only stage flop. It adds a valid/ready handshake, a 2-entry skid buffer so back-pressure never drops a beat, a synchronous flush that turns the stage into a bubble, and a configurable bubble value. It sits between pipeline stages (IF/ID, ID/EX, ...) and is the hazard unit's single point for stalling and squashing a stage.

## Interface
- WIDTH, 15: payload width in bits.
- BUBBLE, {WIDTH{1'b0}}: value driven on out_data whenever out_valid=0 (the NOP encoding).
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  reset; one clock, asynchronous, active-low.
- flush  in  1  synchronous squash, highest priority.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  downstream payload; equals BUBBLE when out_valid=0.
- occupancy  out  2  entries held, 0..2.

## Operation
- Accept means in_valid & in_ready at a rising edge. Deliver means out_valid & out_ready at a rising edge.
- Storage is a main entry driving out_* and a skid entry. States: EMPTY (0 entries), ONE (main entry full), TWO (main and skid entries full).
- EMPTY:
  - accept -> main<=in_data, go to ONE.
  - otherwise stay in EMPTY.
- ONE:
  - accept and deliver -> main<=in_data, stay in ONE.
  - accept without deliver -> skid<=in_data, go to TWO.
  - deliver without accept -> main<=BUBBLE, go to EMPTY.
  - neither -> hold.
- TWO:
  - deliver -> main<=skid, go to ONE.
  - otherwise hold.
  - in_ready=0 in TWO, so no accept is possible.
- in_ready is registered: it is 1 in EMPTY and ONE, and 0 in TWO. It never depends combinationally on out_ready.
- out_valid=1 in ONE and TWO.
- occupancy is 0, 1 or 2 for EMPTY, ONE and TWO.
- flush=1 at an edge:
  - Next state is EMPTY and main<=BUBBLE; the skid content is discarded.
  - A beat handshaken in the same cycle is discarded and is not delivered.
  - in_ready is 1 after the edge.
  - A delivery in the same cycle counts as delivered downstream; squashing it is the downstream stage's responsibility.
- Beat order is strictly FIFO. No beat is duplicated or lost except through flush.

## Timing
- Reset (clrn=0, asynchronous): state EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=0.
- in_ready rises at the first rising edge after clrn is released. Inputs are ignored while clrn=0.
- Reset mid-operation clears everything at once; no partial beat survives.
- Latency is 1 cycle: a beat accepted at edge k is on out_data/out_valid after edge k.
- Throughput is 1 beat/cycle while out_ready=1.
- When out_ready drops, in_ready drops one cycle later. The in-flight beat lands in the skid entry.
- Refill from TWO: a deliver at edge k gives ONE and in_ready=1 after edge k.
- out_data changes only at rising edges or on reset. There is no combinational path from in_* to out_*.

## Configuration
- PIPE_SKID_REG_SKID_EN defined:
  - 2-entry behaviour as above.
  - Registered in_ready.
  - occupancy ranges 0..2.
- PIPE_SKID_REG_SKID_EN undefined:
  - Single entry; the TWO state and the skid register are removed.
  - in_ready = !out_valid | out_ready (combinational), forced to 0 while clrn=0.
  - occupancy ranges 0..1.
  - Flush, BUBBLE and reset behaviour are unchanged.

## Structure
- Package pipe_skid_reg_pkg holds:
  - state typedef st_e {ST_EMPTY, ST_ONE, ST_TWO}.
  - OCC_W=2.
- Sub-module dffe_w: WIDTH-parametrised register with enable, asynchronous active-low clrn, and a reset-value parameter. Instantiated for the main entry (reset value BUBBLE) and the skid entry.
- Top level holds the state machine, the in_ready flop and the load muxes.

## Test plan
- Reset: clrn=0 mid-run with 2 entries held -> out_valid=0, out_data=15'h0000, occupancy=0 immediately. After release, in_ready=1 after the first edge.
- Streaming: out_ready=1, beats 15'h0001..15'h0008 on consecutive cycles -> delivered in order with 1-cycle latency, in_ready stays 1.
- Back-pressure: drop out_ready while sending 15'h0A0A, 15'h0B0B.
  - Expect occupancy=2 and in_ready=0 next cycle.
  - Raise out_ready: 15'h0A0A then 15'h0B0B are delivered, and in_ready=1 after the first delivery.
- Flush in TWO with in_valid=1 and in_data=15'h7FFF:
  - Next cycle out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1.
  - 15'h7FFF never appears.
- BUBBLE=15'h1234: idle and post-flush out_data=15'h1234. Accepting 15'h0055 shows 15'h0055 with out_valid=1.
- Macro undefined: with out_valid=1 and out_ready=0, in_ready=0 in the same cycle. Raising out_ready gives in_ready=1 in the same cycle, and a beat is accepted and delivered at the same edge.
